// File: rtl/uart_tx_buf.sv
// rtl/uart_tx_buf.sv - Buffered 8N1 UART transmitter with edge-triggered push FIFO
//
// Purpose: accepts bytes on the rising edge of sender_ready into a small FIFO
// and serialises them as 8N1 frames (start, 8 data bits LSB first, stop).
// Frames are sent back to back while the FIFO holds data.
//
// Ports:
//   clk            - single clock, all state on rising edge
//   rstn           - synchronous active-low reset
//   sender_ready   - send request level; only its rising edge pushes a byte
//   w_data[7:0]    - byte captured in the request cycle
//   sender_sending - FIFO non-empty or a frame in flight
//   txd            - registered serial output, idle high
//   overflow       - sticky, set when a request finds the FIFO full
//   fifo_count     - current FIFO occupancy
module uart_tx_buf #(
  parameter int CLK_PER_HALF_BIT = 520,
  parameter int FIFO_DEPTH       = 4
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        sender_ready,
  input  logic [7:0]                  w_data,
  output logic                        sender_sending,
  output logic                        txd,
  output logic                        overflow,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int BIT_CLKS = 2 * CLK_PER_HALF_BIT;
  localparam int CW       = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(BIT_CLKS - 1);
  localparam logic [AW:0]   FULL     = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e        state_q;
  logic [7:0]    sr_q;
  logic [CW-1:0] bit_cnt_q;
  logic [2:0]    bit_idx_q;
  logic          txd_q;
  logic          ready_q;
  logic          overflow_q;
  logic [AW:0]   count_q, count_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]    mem_q [FIFO_DEPTH];

  logic req, pop, push, drop, bit_end;

  // A request is the rising edge of sender_ready, so a held level pushes once.
  assign req     = sender_ready & ~ready_q;
  assign bit_end = (bit_cnt_q == '0);
  // The FSM takes the head byte when idle or exactly at the end of a stop bit.
  assign pop     = (count_q != '0) &&
                   ((state_q == IDLE) || ((state_q == STOP) && bit_end));
  // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
  assign push    = req && ((count_q != FULL) || pop);
  assign drop    = req && !push;

  // Pointers are AW bits wide, so they wrap modulo FIFO_DEPTH on their own.
  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= w_data;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ready_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ready_q  <= sender_ready;
      if (drop) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      bit_cnt_q <= '0;
      bit_idx_q <= '0;
      txd_q     <= 1'b1;
    end else begin
      // txd is the line level of the previous cycle's state, one clock behind.
      case (state_q)
        START:   txd_q <= 1'b0;
        DATA:    txd_q <= sr_q[0];
        default: txd_q <= 1'b1;
      endcase

      case (state_q)
        IDLE: begin
          if (pop) begin
            sr_q      <= mem_q[rd_ptr_q];
            bit_cnt_q <= BIT_LAST;
            state_q   <= START;
          end
        end
        START: begin
          if (bit_end) begin
            bit_cnt_q <= BIT_LAST;
            bit_idx_q <= '0;
            state_q   <= DATA;
          end else begin
            bit_cnt_q <= bit_cnt_q - 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            bit_cnt_q <= BIT_LAST;
            sr_q      <= {1'b0, sr_q[7:1]};
            if (bit_idx_q == 3'd7) state_q <= STOP;
            else                   bit_idx_q <= bit_idx_q + 1'b1;
          end else begin
            bit_cnt_q <= bit_cnt_q - 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            if (pop) begin
              sr_q      <= mem_q[rd_ptr_q];
              bit_cnt_q <= BIT_LAST;
              state_q   <= START;
            end else begin
              state_q   <= IDLE;
            end
          end else begin
            bit_cnt_q <= bit_cnt_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign txd            = txd_q;
  assign overflow       = overflow_q;
  assign fifo_count     = count_q;
  assign sender_sending = (state_q != IDLE) || (count_q != '0);

endmodule

// File: tb/tb_uart_tx_buf.sv
// tb/tb_uart_tx_buf.sv - Self-checking randomized bench for uart_tx_buf
module tb_uart_tx_buf;

  localparam int H     = 2;
  localparam int DEPTH = 4;
  localparam int BITC  = 2 * H;
  localparam int FRAME = 10 * BITC;
  localparam int MAXC  = 40000;

  logic       clk = 1'b0;
  logic       rstn;
  logic       sender_ready;
  logic [7:0] w_data;
  logic       sender_sending;
  logic       txd;
  logic       overflow;
  logic [2:0] fifo_count;

  uart_tx_buf #(.CLK_PER_HALF_BIT(H), .FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .sender_ready   (sender_ready),
    .w_data         (w_data),
    .sender_sending (sender_sending),
    .txd            (txd),
    .overflow       (overflow),
    .fifo_count     (fifo_count)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   peak     = 0;
  logic chk_on   = 1'b0;
  logic cap_txd  [MAXC];
  logic cap_send [MAXC];

  // Behavioural reference: a byte queue plus the time the current frame was
  // taken; the line level is read off the 10-bit frame by elapsed time.
  byte unsigned mq[$];
  byte unsigned m_sent[$];
  int          m_left    = 0;
  int          m_pop_cyc = -1000;
  logic [9:0]  m_frame   = '1;
  logic        m_rdy_prev = 1'b1;
  logic        m_ovf     = 1'b0;
  logic        m_txd     = 1'b1;
  int          m_cnt     = 0;
  logic        m_send    = 1'b0;

  initial begin
    int d;
    logic rq, pp;
    byte unsigned b;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      if (!rstn) begin
        mq.delete();
        m_left = 0; m_pop_cyc = -1000; m_ovf = 1'b0; m_rdy_prev = 1'b1; m_txd = 1'b1;
      end else begin
        d = cyc - m_pop_cyc;
        m_txd = (d >= 1 && d <= FRAME) ? m_frame[(d - 1) / BITC] : 1'b1;
        rq = sender_ready && !m_rdy_prev;
        m_rdy_prev = sender_ready;
        if (m_left > 0) m_left = m_left - 1;
        pp = (m_left == 0) && (mq.size() > 0);
        if (pp) begin
          b = mq.pop_front();
          m_sent.push_back(b);
          m_frame = {1'b1, b, 1'b0};
          m_pop_cyc = cyc;
          m_left = FRAME;
        end
        if (rq) begin
          if (mq.size() < DEPTH) mq.push_back(w_data);
          else m_ovf = 1'b1;
        end
      end
      m_cnt  = mq.size();
      m_send = (m_left > 0) || (m_cnt > 0);
    end
  end

  // Capture outputs each cycle and compare against the reference model.
  initial begin
    forever begin
      @(negedge clk);
      if (cyc < MAXC) begin
        cap_txd[cyc]  = txd;
        cap_send[cyc] = sender_sending;
      end
      if (fifo_count > 3'(peak)) peak = int'(fifo_count);
      if (chk_on) begin
        n_checks++;
        if (txd !== m_txd) $display("FAIL model_txd cyc=%0d got=%b exp=%b", cyc, txd, m_txd);
        else n_pass++;
        n_checks++;
        if (fifo_count !== 3'(m_cnt)) $display("FAIL model_count cyc=%0d got=%0d exp=%0d", cyc, fifo_count, m_cnt);
        else n_pass++;
        n_checks++;
        if (sender_sending !== m_send) $display("FAIL model_sending cyc=%0d got=%b exp=%b", cyc, sender_sending, m_send);
        else n_pass++;
        n_checks++;
        if (overflow !== m_ovf) $display("FAIL model_overflow cyc=%0d got=%b exp=%b", cyc, overflow, m_ovf);
        else n_pass++;
      end
    end
  end

  function automatic int find_start(int from, int to);
    for (int i = from; i < to && i < MAXC; i++)
      if (cap_txd[i] === 1'b0) return i;
    return -1;
  endfunction

  function automatic logic [7:0] rx_byte(int st);
    logic [7:0] b;
    for (int j = 0; j < 8; j++) b[j] = cap_txd[st + BITC * (j + 1) + BITC / 2];
    return b;
  endfunction

  task automatic pulse(input logic [7:0] b, output int req_cyc);
    @(negedge clk);
    w_data = b;
    sender_ready = 1'b1;
    req_cyc = cyc + 1;
    @(negedge clk);
    sender_ready = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sender_sending === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rstn = 1'b0; sender_ready = 1'b1; w_data = 8'hFF;
    repeat (3) @(negedge clk);
    chk_on = 1'b1;
    n_checks++; if (txd !== 1'b1) $display("FAIL reset_txd got=%b exp=1", txd); else n_pass++;
    n_checks++; if (fifo_count !== 3'd0) $display("FAIL reset_count got=%0d exp=0", fifo_count); else n_pass++;
    n_checks++; if (sender_sending !== 1'b0) $display("FAIL reset_sending got=%b exp=0", sender_sending); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow got=%b exp=0", overflow); else n_pass++;
    rstn = 1'b1;
    repeat (6) @(negedge clk);
    n_checks++; if (fifo_count !== 3'd0) $display("FAIL reset_held_ready_count got=%0d exp=0", fifo_count); else n_pass++;
    n_checks++; if (sender_sending !== 1'b0) $display("FAIL reset_held_ready_sending got=%b exp=0", sender_sending); else n_pass++;
    sender_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    int n, hi;
    logic [9:0] fr;
    logic exp;
    fr = {1'b1, 8'hA5, 1'b0};
    pulse(8'hA5, n);
    w_data = 8'h3C;
    repeat (60) begin
      @(negedge clk);
      w_data = 8'($urandom);
    end
    n_checks++; if (cap_send[n - 1] !== 1'b0) $display("FAIL single_pre_sending got=%b exp=0", cap_send[n - 1]); else n_pass++;
    for (int s = 0; s < 44; s++) begin
      exp = (s >= 2 && s <= 41) ? fr[(s - 2) / BITC] : 1'b1;
      n_checks++;
      if (cap_txd[n + s] !== exp) $display("FAIL single_wave s=%0d got=%b exp=%b", s, cap_txd[n + s], exp);
      else n_pass++;
    end
    hi = 0;
    for (int s = 0; s < 60; s++) if (cap_send[n + s] === 1'b1) hi++;
    n_checks++; if (hi != 41) $display("FAIL single_sending_len got=%0d exp=41", hi); else n_pass++;
  endtask

  task automatic test_level_hold();
    int n, hi, st;
    logic ok;
    @(negedge clk);
    w_data = 8'h55; sender_ready = 1'b1; n = cyc + 1;
    repeat (200) @(negedge clk);
    sender_ready = 1'b0;
    wait_idle(100, ok);
    n_checks++; if (!ok) $display("FAIL hold_idle_timeout got=busy exp=idle"); else n_pass++;
    hi = 0;
    for (int s = 0; s < 200; s++) if (cap_send[n + s] === 1'b1) hi++;
    n_checks++; if (hi != 41) $display("FAIL hold_sending_len got=%0d exp=41", hi); else n_pass++;
    st = find_start(n, n + 200);
    n_checks++; if (st != n + 2) $display("FAIL hold_start got=%0d exp=%0d", st - n, 2); else n_pass++;
    n_checks++; if (rx_byte(st) !== 8'h55) $display("FAIL hold_byte got=%h exp=55", rx_byte(st)); else n_pass++;
    n_checks++; if (find_start(st + FRAME, n + 200) != -1) $display("FAIL hold_extra_frame got=present exp=none"); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL hold_overflow got=%b exp=0", overflow); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int n0, n1, n2, st, hi;
    logic ok;
    peak = 0;
    pulse(8'h01, n0);
    pulse(8'h02, n1);
    pulse(8'h03, n2);
    wait_idle(200, ok);
    n_checks++; if (!ok) $display("FAIL b2b_idle_timeout got=busy exp=idle"); else n_pass++;
    n_checks++; if (n2 - n0 != 4) $display("FAIL b2b_spacing got=%0d exp=4", n2 - n0); else n_pass++;
    n_checks++; if (peak != 2) $display("FAIL b2b_peak_count got=%0d exp=2", peak); else n_pass++;
    st = n0 + 2;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (cap_txd[st + k * FRAME] !== 1'b0) $display("FAIL b2b_start%0d got=%b exp=0", k, cap_txd[st + k * FRAME]);
      else n_pass++;
      n_checks++;
      if (rx_byte(st + k * FRAME) !== 8'(k + 1)) $display("FAIL b2b_byte%0d got=%h exp=%h", k, rx_byte(st + k * FRAME), 8'(k + 1));
      else n_pass++;
    end
    hi = 0;
    for (int s = 0; s < 140; s++) if (cap_send[n0 + s] === 1'b1) hi++;
    n_checks++; if (hi != 3 * FRAME + 1) $display("FAIL b2b_sending_len got=%0d exp=%0d", hi, 3 * FRAME + 1); else n_pass++;
  endtask

  task automatic test_overflow();
    logic [7:0] b [6];
    int n [6];
    int st;
    logic ok;
    for (int i = 0; i < 6; i++) b[i] = 8'($urandom);
    peak = 0;
    for (int i = 0; i < 6; i++) pulse(b[i], n[i]);
    n_checks++; if (n[5] - n[0] > 11) $display("FAIL ovf_window got=%0d exp<=11", n[5] - n[0]); else n_pass++;
    n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_flag got=%b exp=1", overflow); else n_pass++;
    wait_idle(400, ok);
    repeat (30) @(negedge clk);
    n_checks++; if (!ok) $display("FAIL ovf_idle_timeout got=busy exp=idle"); else n_pass++;
    n_checks++; if (peak != DEPTH) $display("FAIL ovf_peak_count got=%0d exp=%0d", peak, DEPTH); else n_pass++;
    st = n[0] + 2;
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (rx_byte(st + k * FRAME) !== b[k] || cap_txd[st + k * FRAME] !== 1'b0)
        $display("FAIL ovf_byte%0d got=%h exp=%h", k, rx_byte(st + k * FRAME), b[k]);
      else n_pass++;
    end
    n_checks++;
    if (find_start(st + 5 * FRAME, st + 5 * FRAME + 25) != -1) $display("FAIL ovf_sixth_frame got=present exp=none");
    else n_pass++;
    n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_sticky got=%b exp=1", overflow); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int n, n2, r, bad;
    pulse(8'($urandom), n);
    pulse(8'($urandom), n2);
    r = n + 2 + BITC * 5 + 1;
    for (int i = 0; i < 200 && cyc < r - 1; i++) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    n_checks++; if (cyc != r) $display("FAIL rmid_edge got=%0d exp=%0d", cyc, r); else n_pass++;
    n_checks++; if (txd !== 1'b1) $display("FAIL rmid_txd got=%b exp=1", txd); else n_pass++;
    n_checks++; if (sender_sending !== 1'b0) $display("FAIL rmid_sending got=%b exp=0", sender_sending); else n_pass++;
    n_checks++; if (fifo_count !== 3'd0) $display("FAIL rmid_count got=%0d exp=0", fifo_count); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL rmid_overflow got=%b exp=0", overflow); else n_pass++;
    repeat (120) @(negedge clk);
    bad = 0;
    for (int s = 0; s < 120; s++) if (cap_txd[r + s] !== 1'b1 || cap_send[r + s] !== 1'b0) bad++;
    n_checks++; if (bad != 0) $display("FAIL rmid_quiet got=%0d active cycles exp=0", bad); else n_pass++;
  endtask

  task automatic test_wrap();
    logic [7:0] b;
    int n, st;
    logic ok;
    for (int k = 0; k < 10; k++) begin
      b = 8'($urandom);
      pulse(b, n);
      wait_idle(100, ok);
      n_checks++; if (!ok) $display("FAIL wrap%0d_idle_timeout got=busy exp=idle", k); else n_pass++;
      st = find_start(n, n + 10);
      n_checks++; if (st != n + 2) $display("FAIL wrap%0d_start got=%0d exp=2", k, st - n); else n_pass++;
      n_checks++; if (rx_byte(st) !== b) $display("FAIL wrap%0d_byte got=%h exp=%h", k, rx_byte(st), b); else n_pass++;
      n_checks++;
      if (cap_txd[st + FRAME - 1] !== 1'b1) $display("FAIL wrap%0d_stop got=%b exp=1", k, cap_txd[st + FRAME - 1]);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    int sent0, start, pos, nfr;
    logic ok;
    sent0 = m_sent.size();
    start = cyc + 1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      sender_ready = ($urandom_range(0, (i < 1500) ? 3 : 60) == 0);
      w_data = 8'($urandom);
    end
    sender_ready = 1'b0;
    wait_idle(400, ok);
    n_checks++; if (!ok) $display("FAIL rand_idle_timeout got=busy exp=idle"); else n_pass++;
    nfr = m_sent.size() - sent0;
    n_checks++; if (nfr < 10) $display("FAIL rand_frame_count got=%0d exp>=10", nfr); else n_pass++;
    pos = find_start(start, cyc);
    for (int k = sent0; k < m_sent.size(); k++) begin
      n_checks++;
      if (pos < 0) begin
        $display("FAIL rand_missing_frame%0d got=none exp=%h", k - sent0, m_sent[k]);
        break;
      end
      if (rx_byte(pos) !== 8'(m_sent[k])) $display("FAIL rand_byte%0d got=%h exp=%h", k - sent0, rx_byte(pos), m_sent[k]);
      else n_pass++;
      pos = find_start(pos + FRAME, cyc);
    end
    n_checks++; if (pos != -1) $display("FAIL rand_extra_frame got=present exp=none"); else n_pass++;
  endtask

  initial begin
    rstn = 1'b0;
    sender_ready = 1'b0;
    w_data = 8'h00;
    test_reset();
    test_single();
    test_level_hold();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
    test_wrap();
    test_random();
    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
